// File: rtl/chargen_fifo_top_if.sv
// Board-facing pin bundle of the character-generator demo: DIP switches,
// LEDs and the UART pair. The design drives it through the slave modport;
// whatever sits on the board side (or a bench) uses the master modport.
interface chargen_fifo_top_if;
    logic [2:0] dip;
    logic [2:0] led;
    logic       uart_rx;
    logic       uart_tx;

    modport master (
        output dip,
        output uart_rx,
        input  led,
        input  uart_tx
    );

    modport slave (
        input  dip,
        input  uart_rx,
        output led,
        output uart_tx
    );
endinterface

// File: rtl/chargen_fifo_top.sv
// Character-generator demo.
// A generator streams printable ASCII (starting at 'a', wrapping '~' -> ' ')
// into a 2^FIFO_DEPTH-entry FIFO. An 8N1 UART transmitter drains the FIFO
// back-to-back: the next character is popped at the end of the last data
// bit, so the stop bit is driven from its own state and the following start
// bit can begin with no idle gap. LEDs (active-low) show a heartbeat,
// transmitter activity and FIFO-full.
module chargen_fifo_top #(
    parameter int FIFO_DEPTH     = 2,
    parameter int UART_CDIV      = 2,
    parameter int BLINK_INTERVAL = 2
) (
    input  logic               clk,
    input  logic               n_rst,
    chargen_fifo_top_if.slave  bus
);

    localparam int ENTRIES = 1 << FIFO_DEPTH;
    localparam int PW      = FIFO_DEPTH + 1;
    localparam int DW      = $clog2(UART_CDIV + 1);
    localparam int BW      = $clog2(BLINK_INTERVAL + 1);

    localparam logic [PW-1:0] NR_FULL    = PW'(ENTRIES);
    localparam logic [DW-1:0] DIV_LAST   = DW'(UART_CDIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_INTERVAL - 1);

    localparam logic [7:0] CHAR_FIRST = 8'h61;   // 'a'
    localparam logic [7:0] CHAR_LAST  = 8'h7E;   // '~'
    localparam logic [7:0] CHAR_WRAP  = 8'h20;   // ' '

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Character generator and FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    fifo_in_q, fifo_in_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] nr_q, nr_d;
    logic [7:0]    mem [ENTRIES];

    logic          fifo_full;
    logic          fifo_empty;
    logic          wr_en;
    logic          rd_en;
    logic [7:0]    fifo_head;

    assign fifo_full  = (nr_q == NR_FULL);
    assign fifo_empty = (nr_q == '0);
    // The generator always has a character ready, so it writes whenever
    // there is room; a full FIFO blocks the write.
    assign wr_en      = !fifo_full;
    assign fifo_head  = mem[rp_q[FIFO_DEPTH-1:0]];

    // Next generator character, pointer advance and occupancy count.
    always_comb begin
        fifo_in_d = fifo_in_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        nr_d      = nr_q;
        if (wr_en) begin
            fifo_in_d = (fifo_in_q == CHAR_LAST) ? CHAR_WRAP : fifo_in_q + 8'd1;
            wp_d      = wp_q + PW'(1);
        end
        if (rd_en) begin
            rp_d = rp_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   nr_d = nr_q + PW'(1);
            2'b01:   nr_d = nr_q - PW'(1);
            default: nr_d = nr_q;
        endcase
    end

    // Generator / FIFO state registers.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            fifo_in_q <= CHAR_FIRST;
            wp_q      <= '0;
            rp_q      <= '0;
            nr_q      <= '0;
        end else begin
            fifo_in_q <= fifo_in_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            nr_q      <= nr_d;
        end
    end

    // FIFO storage write port; contents need no reset because the count
    // gates every read.
    always_ff @(posedge clk) begin
        if (wr_en && !n_rst) begin
            mem[wp_q[FIFO_DEPTH-1:0]] <= fifo_in_q;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    tx_state_t     state_q, state_d;
    logic [7:0]    data_in_q, data_in_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          preload_q, preload_d;
    logic          sending_q, sending_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (div_q == DIV_LAST);

    // Transmitter next-state: bit timing, pops and the preload for the
    // following frame. The line level is computed from the next state so
    // that the registered uart_tx lines up with state_q.
    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        bit_d     = bit_q;
        div_d     = div_q;
        preload_d = preload_q;
        sending_d = sending_q;
        rd_en     = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    rd_en     = 1'b1;
                    data_in_d = fifo_head;
                    state_d   = TX_START;
                    div_d     = '0;
                    sending_d = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        // Grab the next character now; the stop bit no
                        // longer depends on data_in.
                        state_d = TX_STOP;
                        if (!fifo_empty) begin
                            rd_en     = 1'b1;
                            data_in_d = fifo_head;
                            preload_d = 1'b1;
                        end else begin
                            preload_d = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    div_d = '0;
                    if (preload_q) begin
                        preload_d = 1'b0;
                        state_d   = TX_START;
                    end else begin
                        state_d   = TX_IDLE;
                        sending_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                state_d   = TX_IDLE;
                sending_d = 1'b0;
            end
        endcase

        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = data_in_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // Transmitter state register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= TX_IDLE;
            data_in_q <= 8'h00;
            bit_q     <= '0;
            div_q     <= '0;
            preload_q <= 1'b0;
            sending_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_in_q <= data_in_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            preload_q <= preload_d;
            sending_q <= sending_d;
            tx_q      <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Heartbeat
    // ------------------------------------------------------------------
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    // Toggle the heartbeat once every BLINK_INTERVAL cycles.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    // Heartbeat registers; the LED starts dark (high).
    always_ff @(posedge clk) begin
        if (n_rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.uart_tx = tx_q;
    assign bus.led     = {~fifo_full, ~sending_q, blink_q};

    // DIP switches and the receive line are reserved; pointer MSBs exist
    // only to keep full and empty distinct in the pointer encoding.
    logic unused_ok;
    assign unused_ok = ^{bus.dip, bus.uart_rx, rp_q[FIFO_DEPTH], wp_q[FIFO_DEPTH]};

endmodule

// File: tb/tb_chargen_fifo_top.sv
// Bench for chargen_fifo_top (FIFO_DEPTH=2, UART_CDIV=2, BLINK_INTERVAL=2).
// A cycle-by-cycle table covers reset and the first frame; hand-written
// sequences cover the contiguous stream, the '~' -> ' ' wrap and a
// mid-frame reset.
module tb_chargen_fifo_top;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;

    chargen_fifo_top_if bus ();

    chargen_fifo_top #(
        .FIFO_DEPTH    (2),
        .UART_CDIV     (2),
        .BLINK_INTERVAL(2)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       n_rst;
        logic       exp_tx;
        logic [2:0] exp_led;
        logic [2:0] exp_nr;
        logic       chk_data;
        logic [7:0] exp_data;
        logic [7:0] exp_fifo_in;
    } vec_t;

    vec_t vecs [22];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] next_char(input logic [7:0] c);
        return (c == 8'h7E) ? 8'h20 : c + 8'd1;
    endfunction

    // Wait (bounded) for a start bit, decode one 8N1 frame at 2 cycles/bit,
    // checking each bit is held and that data_in holds exp_next during stop.
    // Returns positioned on the cycle after the stop bit.
    task automatic recv_char(input logic [7:0] exp_next, output logic [7:0] c, output int gap);
        logic first;
        c   = 8'h00;
        gap = 0;
        while (bus.uart_tx !== 1'b0 && gap < 100) begin
            step();
            gap++;
        end
        if (bus.uart_tx !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL start_timeout tx=%b required 0 within 100 cycles", bus.uart_tx);
            return;
        end
        step();
        chk("start_hold", 32'(bus.uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            first = bus.uart_tx;
            c[i]  = first;
            step();
            chk("bit_hold", 32'(bus.uart_tx), 32'(first));
        end
        step();
        chk("stop_bit", 32'(bus.uart_tx), 32'd1);
        chk("stop_data_in", 32'(dut.data_in_q), 32'(exp_next));
        step();
        chk("stop_hold", 32'(bus.uart_tx), 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_c;
        logic [7:0] got;
        int         gap;

        bus.dip     = 3'b000;
        bus.uart_rx = 1'b1;

        // Row 0 is the reset edge; rows 1..21 are cycles 0..20 after release.
        //            n_rst tx    led     nr    chk   data   fifo_in
        vecs[0]  = '{1'b1, 1'b1, 3'b111, 3'd0, 1'b0, 8'h00, 8'h61};
        vecs[1]  = '{1'b0, 1'b1, 3'b111, 3'd1, 1'b0, 8'h00, 8'h62};
        vecs[2]  = '{1'b0, 1'b0, 3'b100, 3'd1, 1'b1, 8'h61, 8'h63};
        vecs[3]  = '{1'b0, 1'b0, 3'b100, 3'd2, 1'b1, 8'h61, 8'h64};
        vecs[4]  = '{1'b0, 1'b1, 3'b101, 3'd3, 1'b1, 8'h61, 8'h65};
        vecs[5]  = '{1'b0, 1'b1, 3'b001, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[6]  = '{1'b0, 1'b0, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[7]  = '{1'b0, 1'b0, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[8]  = '{1'b0, 1'b0, 3'b001, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[9]  = '{1'b0, 1'b0, 3'b001, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[10] = '{1'b0, 1'b0, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[11] = '{1'b0, 1'b0, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[12] = '{1'b0, 1'b0, 3'b001, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[13] = '{1'b0, 1'b0, 3'b001, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[14] = '{1'b0, 1'b1, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[15] = '{1'b0, 1'b1, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[16] = '{1'b0, 1'b1, 3'b001, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[17] = '{1'b0, 1'b1, 3'b001, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[18] = '{1'b0, 1'b0, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[19] = '{1'b0, 1'b0, 3'b000, 3'd4, 1'b1, 8'h61, 8'h66};
        vecs[20] = '{1'b0, 1'b1, 3'b101, 3'd3, 1'b1, 8'h62, 8'h66};
        vecs[21] = '{1'b0, 1'b1, 3'b001, 3'd4, 1'b1, 8'h62, 8'h67};

        @(negedge clk);

        // Reset and first frame, cycle by cycle.
        for (int r = 0; r < 22; r++) begin
            n_rst = vecs[r].n_rst;
            step();
            chk("tbl_uart_tx", 32'(bus.uart_tx), 32'(vecs[r].exp_tx));
            chk("tbl_led", 32'(bus.led), 32'(vecs[r].exp_led));
            chk("tbl_nr", 32'(dut.nr_q), 32'(vecs[r].exp_nr));
            chk("tbl_fifo_in", 32'(dut.fifo_in_q), 32'(vecs[r].exp_fifo_in));
            if (vecs[r].chk_data) begin
                chk("tbl_data_in", 32'(dut.data_in_q), 32'(vecs[r].exp_data));
            end
            if (r == 0) begin
                chk("rst_rp", 32'(dut.rp_q), 32'd0);
                chk("rst_wp", 32'(dut.wp_q), 32'd0);
            end
            $display("row %0d n_rst=%b tx=%b led=%b nr=%0d data_in=%h fifo_in=%h",
                     r, n_rst, bus.uart_tx, bus.led, dut.nr_q, dut.data_in_q, dut.fifo_in_q);
        end

        // Fresh stream: "abcde..." through '~', ' ', '!' with no gaps.
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        exp_c = 8'h61;
        for (int n = 0; n < 32; n++) begin
            recv_char(next_char(exp_c), got, gap);
            chk("stream_char", 32'(got), 32'(exp_c));
            if (n == 0) begin
                chk("first_start_gap", 32'(gap), 32'd2);
            end else begin
                chk("frame_gap", 32'(gap), 32'd0);
            end
            $display("frame %0d char=%h (%c) gap=%0d", n, got, got, gap);
            exp_c = next_char(exp_c);
        end

        // Mid-frame reset: move into data bit 1 of the next frame.
        for (int i = 0; i < 4; i++) begin
            step();
        end
        n_rst = 1'b1;
        step();
        chk("midrst_uart_tx", 32'(bus.uart_tx), 32'd1);
        chk("midrst_led", 32'(bus.led), 32'h7);
        chk("midrst_nr", 32'(dut.nr_q), 32'd0);
        chk("midrst_rp", 32'(dut.rp_q), 32'd0);
        chk("midrst_wp", 32'(dut.wp_q), 32'd0);
        chk("midrst_fifo_in", 32'(dut.fifo_in_q), 32'h61);
        $display("mid-frame reset tx=%b led=%b nr=%0d", bus.uart_tx, bus.led, dut.nr_q);
        n_rst = 1'b0;
        recv_char(8'h62, got, gap);
        chk("restart_char", 32'(got), 32'h61);
        chk("restart_gap", 32'(gap), 32'd2);
        $display("restart char=%h (%c) gap=%0d", got, got, gap);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
